// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BTB with 2-bit counters and flush/redirect.
// Ports: fetch lookup (FetchValid/FetchPc -> Pred*), resolution (Res*, *Instr) -> FlushPipePC/NPC/RedirectPc, MispredCnt.
module branch_predict_unit #(
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              FetchValid,
   input  logic [ADDR_W-1:0] FetchPc,
   output logic              PredValid,
   output logic              PredTaken,
   output logic [ADDR_W-1:0] PredTarget,
   input  logic              ResValid,
   input  logic [ADDR_W-1:0] ResPc,
   input  logic              BranchInstr,
   input  logic              JumpInstr,
   input  logic              JumpTaken,
   input  logic [ADDR_W-1:0] ResTarget,
   input  logic              ResPredTaken,
   output logic              FlushPipePC,
   output logic [1:0]        NPC,
   output logic [ADDR_W-1:0] RedirectPc,
   output logic [CNT_W-1:0]  MispredCnt
);
   localparam int TAG_W   = ADDR_W - IDX_W - 2;
   localparam int ENTRIES = 1 << IDX_W;

   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_TGT = 2'b01;
   localparam logic [1:0] NPC_PC4 = 2'b10;

   // Table state: valid and counter are reset, tag/target/jump are not
   logic              valid_q [ENTRIES];
   logic              valid_d [ENTRIES];
   logic [1:0]        ctr_q   [ENTRIES];
   logic [1:0]        ctr_d   [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   logic [TAG_W-1:0]  tag_d   [ENTRIES];
   logic [ADDR_W-1:0] tgt_q   [ENTRIES];
   logic [ADDR_W-1:0] tgt_d   [ENTRIES];
   logic              jmp_q   [ENTRIES];
   logic              jmp_d   [ENTRIES];

   logic              pred_valid_q, pred_valid_d;
   logic              pred_taken_q, pred_taken_d;
   logic [ADDR_W-1:0] pred_target_q, pred_target_d;
   logic              flush_q, flush_d;
   logic [1:0]        npc_q, npc_d;
   logic [ADDR_W-1:0] redirect_q, redirect_d;
   logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

   logic [IDX_W-1:0]  f_idx, r_idx;
   logic [TAG_W-1:0]  f_tag, r_tag;
   logic              f_hit, r_hit;
   logic              is_jump, is_branch, act_taken, mispred;
   logic              unused_bits;

   assign unused_bits = ^{FetchPc[1:0], ResPc[1:0]};

   assign f_idx = FetchPc[IDX_W+1:2];
   assign f_tag = FetchPc[ADDR_W-1:IDX_W+2];
   assign r_idx = ResPc[IDX_W+1:2];
   assign r_tag = ResPc[ADDR_W-1:IDX_W+2];

   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

   // A branch flagged together with a jump is handled as a jump
   assign is_jump   = JumpInstr;
   assign is_branch = BranchInstr & ~JumpInstr;
   assign act_taken = JumpTaken | JumpInstr;
   assign mispred   = ResValid & (is_branch | is_jump) &
                      (act_taken != ResPredTaken);

   // Lookup reads the pre-update table, giving read-before-write
   always_comb begin
      pred_valid_d  = FetchValid & f_hit;
      pred_taken_d  = FetchValid & f_hit & (jmp_q[f_idx] | ctr_q[f_idx][1]);
      pred_target_d = valid_q[f_idx] ? tgt_q[f_idx] : '0;
   end

   always_comb begin
      valid_d = valid_q;
      ctr_d   = ctr_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      jmp_d   = jmp_q;
      if (ResValid) begin
         if (is_jump) begin
            valid_d[r_idx] = 1'b1;
            tag_d[r_idx]   = r_tag;
            tgt_d[r_idx]   = ResTarget;
            jmp_d[r_idx]   = 1'b1;
            ctr_d[r_idx]   = 2'b11;
         end else if (is_branch && r_hit) begin
            if (JumpTaken) begin
               tgt_d[r_idx] = ResTarget;
               if (ctr_q[r_idx] != 2'b11)
                  ctr_d[r_idx] = ctr_q[r_idx] + 2'd1;
            end else if (ctr_q[r_idx] != 2'b00) begin
               ctr_d[r_idx] = ctr_q[r_idx] - 2'd1;
            end
         end else if (is_branch && JumpTaken) begin
            valid_d[r_idx] = 1'b1;
            tag_d[r_idx]   = r_tag;
            tgt_d[r_idx]   = ResTarget;
            jmp_d[r_idx]   = 1'b0;
            ctr_d[r_idx]   = 2'b10;
         end
      end
   end

   always_comb begin
      flush_d    = mispred;
      npc_d      = NPC_SEQ;
      redirect_d = '0;
      if (mispred) begin
         npc_d      = act_taken ? NPC_TGT : NPC_PC4;
         redirect_d = act_taken ? ResTarget : ResPc + ADDR_W'(4);
      end
      mis_cnt_d = mis_cnt_q;
      if (mispred && (mis_cnt_q != '1))
         mis_cnt_d = mis_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b00;
         end
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
         flush_q       <= 1'b0;
         npc_q         <= NPC_SEQ;
         redirect_q    <= '0;
         mis_cnt_q     <= '0;
      end else begin
         valid_q       <= valid_d;
         ctr_q         <= ctr_d;
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         flush_q       <= flush_d;
         npc_q         <= npc_d;
         redirect_q    <= redirect_d;
         mis_cnt_q     <= mis_cnt_d;
      end
   end

   // Payload storage; writes are dropped in the reset cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q <= tag_d;
         tgt_q <= tgt_d;
         jmp_q <= jmp_d;
      end
   end

   assign PredValid  = pred_valid_q;
   assign PredTaken  = pred_taken_q;
   assign PredTarget = pred_target_q;
   assign FlushPipePC = flush_q;
   assign NPC        = npc_q;
   assign RedirectPc = redirect_q;
   assign MispredCnt = mis_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit (small CNT_W to reach saturation).
// Each task drives one scenario and checks outputs #1 after the clock edge.
module tb_branch_predict_unit;
   localparam int ADDR_W = 32;
   localparam int IDX_W  = 4;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              FetchValid;
   logic [ADDR_W-1:0] FetchPc;
   logic              PredValid;
   logic              PredTaken;
   logic [ADDR_W-1:0] PredTarget;
   logic              ResValid;
   logic [ADDR_W-1:0] ResPc;
   logic              BranchInstr;
   logic              JumpInstr;
   logic              JumpTaken;
   logic [ADDR_W-1:0] ResTarget;
   logic              ResPredTaken;
   logic              FlushPipePC;
   logic [1:0]        NPC;
   logic [ADDR_W-1:0] RedirectPc;
   logic [CNT_W-1:0]  MispredCnt;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   branch_predict_unit #(
      .ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .FetchValid(FetchValid), .FetchPc(FetchPc),
      .PredValid(PredValid), .PredTaken(PredTaken),
      .PredTarget(PredTarget),
      .ResValid(ResValid), .ResPc(ResPc),
      .BranchInstr(BranchInstr), .JumpInstr(JumpInstr),
      .JumpTaken(JumpTaken), .ResTarget(ResTarget),
      .ResPredTaken(ResPredTaken),
      .FlushPipePC(FlushPipePC), .NPC(NPC),
      .RedirectPc(RedirectPc), .MispredCnt(MispredCnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      FetchValid = 0; FetchPc = '0;
      ResValid = 0; ResPc = '0; BranchInstr = 0; JumpInstr = 0;
      JumpTaken = 0; ResTarget = '0; ResPredTaken = 0;
   endtask

   task automatic res(input logic [31:0] pc, input logic br,
                      input logic jp, input logic tk,
                      input logic [31:0] tgt, input logic pt);
      ResValid = 1; ResPc = pc; BranchInstr = br; JumpInstr = jp;
      JumpTaken = tk; ResTarget = tgt; ResPredTaken = pt;
   endtask

   task automatic fetch(input logic [31:0] pc);
      FetchValid = 1; FetchPc = pc;
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      step(); step();
      rst = 0; fetch(32'h100);
      step();
      total++;
      if (PredValid !== 1'b0) $display("FAIL reset_predvalid got %b want 0", PredValid);
      else passed++;
      total++;
      if (FlushPipePC !== 1'b0 || NPC !== 2'b00 || RedirectPc !== 32'h0)
         $display("FAIL reset_flush got %b/%b/%h want 0/00/0", FlushPipePC, NPC, RedirectPc);
      else passed++;
      total++;
      if (MispredCnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", MispredCnt);
      else passed++;
      idle();
   endtask

   task automatic test_alloc_taken();
      res(32'h100, 1, 0, 1, 32'h200, 0);
      step();
      total++;
      if (FlushPipePC !== 1 || NPC !== 2'b01 || RedirectPc !== 32'h200)
         $display("FAIL alloc_flush got %b/%b/%h want 1/01/200", FlushPipePC, NPC, RedirectPc);
      else passed++;
      total++;
      if (MispredCnt !== 4'd1) $display("FAIL alloc_cnt got %0d want 1", MispredCnt);
      else passed++;
      idle(); fetch(32'h100);
      step();
      total++;
      if (PredValid !== 1 || PredTaken !== 1 || PredTarget !== 32'h200)
         $display("FAIL alloc_lookup got %b/%b/%h want 1/1/200", PredValid, PredTaken, PredTarget);
      else passed++;
      total++;
      if (FlushPipePC !== 0) $display("FAIL flush_pulse got %b want 0", FlushPipePC);
      else passed++;
      idle();
      step();
      total++;
      if (PredValid !== 0 || PredTaken !== 0)
         $display("FAIL nofetch_pred got %b/%b want 0/0", PredValid, PredTaken);
      else passed++;
   endtask

   task automatic test_counter_dec();
      res(32'h100, 1, 0, 0, 32'h0, 1);
      step();
      total++;
      if (FlushPipePC !== 1 || NPC !== 2'b10 || RedirectPc !== 32'h104)
         $display("FAIL nt_flush got %b/%b/%h want 1/10/104", FlushPipePC, NPC, RedirectPc);
      else passed++;
      total++;
      if (MispredCnt !== 4'd2) $display("FAIL nt_cnt got %0d want 2", MispredCnt);
      else passed++;
      res(32'h100, 1, 0, 0, 32'h0, 0);
      fetch(32'h100);
      step();
      total++;
      if (PredValid !== 1 || PredTaken !== 0)
         $display("FAIL weak_nt_lookup got %b/%b want 1/0", PredValid, PredTaken);
      else passed++;
      total++;
      if (FlushPipePC !== 0 || NPC !== 2'b00 || RedirectPc !== 32'h0)
         $display("FAIL correct_noflush got %b/%b/%h want 0/00/0", FlushPipePC, NPC, RedirectPc);
      else passed++;
      res(32'h100, 1, 0, 0, 32'h0, 0);
      FetchValid = 0;
      step();
      idle(); fetch(32'h100);
      step();
      total++;
      if (PredValid !== 1 || PredTaken !== 0 || MispredCnt !== 4'd2)
         $display("FAIL strong_nt got %b/%b/%0d want 1/0/2", PredValid, PredTaken, MispredCnt);
      else passed++;
      idle();
   endtask

   task automatic test_same_cycle();
      // counter 00 -> 01 on this update; old target is 0x200
      res(32'h100, 1, 0, 1, 32'h300, 0);
      fetch(32'h100);
      step();
      total++;
      if (PredValid !== 1 || PredTaken !== 0 || PredTarget !== 32'h200)
         $display("FAIL rbw_old got %b/%b/%h want 1/0/200", PredValid, PredTaken, PredTarget);
      else passed++;
      idle(); fetch(32'h100);
      step();
      total++;
      if (PredValid !== 1 || PredTaken !== 0 || PredTarget !== 32'h300)
         $display("FAIL rbw_new got %b/%b/%h want 1/0/300", PredValid, PredTaken, PredTarget);
      else passed++;
      idle();
      res(32'h140, 1, 0, 1, 32'h400, 1);
      step();
      total++;
      if (FlushPipePC !== 0 || MispredCnt !== 4'd3)
         $display("FAIL alias_noflush got %b/%0d want 0/3", FlushPipePC, MispredCnt);
      else passed++;
      idle(); fetch(32'h100);
      step();
      total++;
      if (PredValid !== 0) $display("FAIL alias_miss got %b want 0", PredValid);
      else passed++;
      fetch(32'h140);
      step();
      total++;
      if (PredValid !== 1 || PredTaken !== 1 || PredTarget !== 32'h400)
         $display("FAIL alias_hit got %b/%b/%h want 1/1/400", PredValid, PredTaken, PredTarget);
      else passed++;
      idle();
   endtask

   task automatic test_jump();
      res(32'h184, 0, 1, 0, 32'h500, 0);
      step();
      total++;
      if (FlushPipePC !== 1 || NPC !== 2'b01 || RedirectPc !== 32'h500 || MispredCnt !== 4'd4)
         $display("FAIL jump_flush got %b/%b/%h/%0d want 1/01/500/4", FlushPipePC, NPC, RedirectPc, MispredCnt);
      else passed++;
      idle(); fetch(32'h184);
      step();
      total++;
      if (PredValid !== 1 || PredTaken !== 1 || PredTarget !== 32'h500)
         $display("FAIL jump_lookup got %b/%b/%h want 1/1/500", PredValid, PredTaken, PredTarget);
      else passed++;
      idle();
      res(32'h184, 1, 1, 0, 32'h600, 1);
      step();
      total++;
      if (FlushPipePC !== 0 || MispredCnt !== 4'd4)
         $display("FAIL both_as_jump got %b/%0d want 0/4", FlushPipePC, MispredCnt);
      else passed++;
      idle(); fetch(32'h184);
      step();
      total++;
      if (PredValid !== 1 || PredTaken !== 1 || PredTarget !== 32'h600)
         $display("FAIL jump_retarget got %b/%b/%h want 1/1/600", PredValid, PredTaken, PredTarget);
      else passed++;
      idle();
   endtask

   task automatic test_non_control();
      res(32'h188, 0, 0, 1, 32'h800, 0);
      step();
      total++;
      if (FlushPipePC !== 0 || MispredCnt !== 4'd4)
         $display("FAIL nonctl_flush got %b/%0d want 0/4", FlushPipePC, MispredCnt);
      else passed++;
      idle(); fetch(32'h188);
      step();
      total++;
      if (PredValid !== 0) $display("FAIL nonctl_alloc got %b want 0", PredValid);
      else passed++;
      idle();
   endtask

   task automatic test_back_to_back();
      res(32'h200, 1, 0, 1, 32'h700, 0);
      step();
      total++;
      if (FlushPipePC !== 1 || NPC !== 2'b01 || RedirectPc !== 32'h700 || MispredCnt !== 4'd5)
         $display("FAIL b2b_first got %b/%b/%h/%0d want 1/01/700/5", FlushPipePC, NPC, RedirectPc, MispredCnt);
      else passed++;
      res(32'h20C, 1, 0, 0, 32'h0, 1);
      step();
      total++;
      if (FlushPipePC !== 1 || NPC !== 2'b10 || RedirectPc !== 32'h210 || MispredCnt !== 4'd6)
         $display("FAIL b2b_second got %b/%b/%h/%0d want 1/10/210/6", FlushPipePC, NPC, RedirectPc, MispredCnt);
      else passed++;
      idle();
      step();
      total++;
      if (FlushPipePC !== 0 || NPC !== 2'b00)
         $display("FAIL b2b_end got %b/%b want 0/00", FlushPipePC, NPC);
      else passed++;
   endtask

   task automatic test_wrap_sat();
      res(32'hFFFF_FFFC, 1, 0, 0, 32'h0, 1);
      step();
      total++;
      if (FlushPipePC !== 1 || NPC !== 2'b10 || RedirectPc !== 32'h0 || MispredCnt !== 4'd7)
         $display("FAIL wrap got %b/%b/%h/%0d want 1/10/0/7", FlushPipePC, NPC, RedirectPc, MispredCnt);
      else passed++;
      for (int i = 0; i < 10; i++) begin
         res(32'h300, 1, 0, 0, 32'h0, 1);
         step();
      end
      total++;
      if (MispredCnt !== 4'hF) $display("FAIL sat_reach got %0d want 15", MispredCnt);
      else passed++;
      res(32'h300, 1, 0, 0, 32'h0, 1);
      step();
      total++;
      if (MispredCnt !== 4'hF || FlushPipePC !== 1)
         $display("FAIL sat_hold got %0d/%b want 15/1", MispredCnt, FlushPipePC);
      else passed++;
      idle();
   endtask

   task automatic test_reset_override();
      rst = 1;
      res(32'h190, 1, 0, 1, 32'h900, 0);
      fetch(32'h184);
      step();
      total++;
      if (FlushPipePC !== 0 || MispredCnt !== 4'd0 || PredValid !== 0)
         $display("FAIL rst_ovr got %b/%0d/%b want 0/0/0", FlushPipePC, MispredCnt, PredValid);
      else passed++;
      rst = 0; idle(); fetch(32'h190);
      step();
      total++;
      if (PredValid !== 0 || FlushPipePC !== 0)
         $display("FAIL rst_discard got %b/%b want 0/0", PredValid, FlushPipePC);
      else passed++;
      fetch(32'h184);
      step();
      total++;
      if (PredValid !== 0) $display("FAIL rst_clear got %b want 0", PredValid);
      else passed++;
      idle();
   endtask

   initial begin
      idle(); rst = 1;
      test_reset();
      test_alloc_taken();
      test_counter_dec();
      test_same_cycle();
      test_jump();
      test_non_control();
      test_back_to_back();
      test_wrap_sat();
      test_reset_override();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
